// File: rtl/gmii_rx_frame.sv
// rtl/gmii_rx_frame.sv - GMII receive framer: preamble/SFD strip, optional FCS strip/check, frame statistics
// Writes body bytes to a FIFO port through a small hold line so FCS bytes can be withheld.
module gmii_rx_frame #(
  parameter int CNT_W     = 11,
  parameter int STAT_W    = 16,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int STRIP_FCS = 1,
  parameter int FCS_CHECK = 1
) (
  input  logic              RCLK,
  input  logic              RST,
  input  logic [7:0]        RXD,
  input  logic              RXDV,
  input  logic              RXER,
  output logic [7:0]        FIFO_WDAT,
  output logic              FIFO_WEN,
  output logic              FIFO_WEOD,
  output logic              FIFO_WERR,
  input  logic              FIFO_AFULL,
  output logic [CNT_W-1:0]  FIFO_WCNT,
  output logic [STAT_W-1:0] FRM_CNT,
  output logic [STAT_W-1:0] ERR_CNT,
  output logic [STAT_W-1:0] DROP_CNT
);

  localparam int H     = 1 + 4 * STRIP_FCS;
  localparam int LEN_W = $clog2(MAX_LEN + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_PREA, S_BODY, S_DROP} state_t;

  state_t           r_state;
  logic [7:0]       r_rxd;
  logic             r_dv;
  logic             r_er;
  logic [LEN_W-1:0] r_len;
  logic             r_err_rx;
  logic [31:0]      r_crc;
  logic [7:0]       r_hold [0:H-1];

  logic [31:0]      w_crc_next;
  logic [7:0]       w_oldest;
  logic             w_fcs_bad;
  logic             w_err_end;

  // MSB-first CRC-32 register fed LSB-first per byte; a clean frame leaves residue C704DD7B
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    logic        fb;
    v = c;
    for (int i = 0; i < 8; i++) begin
      fb = v[31] ^ d[i];
      v  = {v[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return v;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign w_crc_next = crc32_byte(r_crc, r_rxd);
  assign w_oldest   = r_hold[H-1];
  assign w_fcs_bad  = (FCS_CHECK != 0) && (r_crc != 32'hC704DD7B);
  assign w_err_end  = r_err_rx | (r_len < LEN_W'(MIN_LEN)) | w_fcs_bad;

  always_ff @(posedge RCLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_rxd     <= '0;
      r_dv      <= 1'b0;
      r_er      <= 1'b0;
      r_len     <= '0;
      r_err_rx  <= 1'b0;
      r_crc     <= '0;
      for (int i = 0; i < H; i++) r_hold[i] <= '0;
      FIFO_WDAT <= '0;
      FIFO_WEN  <= 1'b0;
      FIFO_WEOD <= 1'b0;
      FIFO_WERR <= 1'b0;
      FIFO_WCNT <= '0;
      FRM_CNT   <= '0;
      ERR_CNT   <= '0;
      DROP_CNT  <= '0;
    end else begin
      r_rxd     <= RXD;
      r_dv      <= RXDV;
      r_er      <= RXER;
      FIFO_WEN  <= 1'b0;
      FIFO_WEOD <= 1'b0;
      FIFO_WERR <= 1'b0;

      case (r_state)
        S_IDLE: begin
          FIFO_WCNT <= '0;
          if (r_dv) begin
            if (FIFO_AFULL) begin
              r_state  <= S_DROP;
              DROP_CNT <= sat_inc(DROP_CNT);
            end else begin
              r_state <= S_PREA;
            end
          end
        end

        S_PREA: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end else if (r_rxd == 8'hD5) begin
            r_state  <= S_BODY;
            r_len    <= '0;
            r_err_rx <= 1'b0;
            r_crc    <= 32'hFFFF_FFFF;
          end else if (r_rxd != 8'h55) begin
            r_state  <= S_DROP;
            DROP_CNT <= sat_inc(DROP_CNT);
          end
        end

        S_BODY: begin
          if (r_dv && (r_len == LEN_W'(MAX_LEN))) begin
            // Giant: close what is held as a bad frame and discard the rest
            r_state   <= S_DROP;
            FIFO_WEN  <= 1'b1;
            FIFO_WDAT <= w_oldest;
            FIFO_WEOD <= 1'b1;
            FIFO_WERR <= 1'b1;
            FIFO_WCNT <= FIFO_WCNT + CNT_W'(1);
            ERR_CNT   <= sat_inc(ERR_CNT);
          end else if (r_dv) begin
            r_hold[0] <= r_rxd;
            for (int i = 1; i < H; i++) r_hold[i] <= r_hold[i-1];
            r_len    <= r_len + LEN_W'(1);
            r_crc    <= w_crc_next;
            r_err_rx <= r_err_rx | r_er;
            if (r_len >= LEN_W'(H)) begin
              FIFO_WEN  <= 1'b1;
              FIFO_WDAT <= w_oldest;
              FIFO_WCNT <= FIFO_WCNT + CNT_W'(1);
            end
          end else begin
            r_state <= S_IDLE;
            if (r_len < LEN_W'(H)) begin
              DROP_CNT <= sat_inc(DROP_CNT);
            end else begin
              FIFO_WEN  <= 1'b1;
              FIFO_WDAT <= w_oldest;
              FIFO_WEOD <= 1'b1;
              FIFO_WERR <= w_err_end;
              FIFO_WCNT <= FIFO_WCNT + CNT_W'(1);
              if (w_err_end) ERR_CNT <= sat_inc(ERR_CNT);
              else           FRM_CNT <= sat_inc(FRM_CNT);
            end
          end
        end

        S_DROP: begin
          if (!r_dv) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb/tb_gmii_rx_frame.sv - randomized frame-level check of gmii_rx_frame in strip/check and raw configurations
module tb_gmii_rx_frame;
  localparam int MAXL = 1518;
  localparam int MINL = 64;

  logic        RCLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RXD = 8'h00;
  logic        RXDV = 1'b0;
  logic        RXER = 1'b0;
  logic        FIFO_AFULL = 1'b0;

  logic [7:0]  a_wdat, b_wdat;
  logic        a_wen, a_weod, a_werr, b_wen, b_weod, b_werr;
  logic [10:0] a_wcnt, b_wcnt;
  logic [15:0] a_frm, a_err, a_drop, b_frm, b_err, b_drop;

  always #4 RCLK = ~RCLK;

  gmii_rx_frame #(.CNT_W(11), .STAT_W(16), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                  .STRIP_FCS(1), .FCS_CHECK(1)) dut_a (
    .RCLK(RCLK), .RST(RST), .RXD(RXD), .RXDV(RXDV), .RXER(RXER),
    .FIFO_WDAT(a_wdat), .FIFO_WEN(a_wen), .FIFO_WEOD(a_weod), .FIFO_WERR(a_werr),
    .FIFO_AFULL(FIFO_AFULL), .FIFO_WCNT(a_wcnt),
    .FRM_CNT(a_frm), .ERR_CNT(a_err), .DROP_CNT(a_drop));

  gmii_rx_frame #(.CNT_W(11), .STAT_W(16), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                  .STRIP_FCS(0), .FCS_CHECK(0)) dut_b (
    .RCLK(RCLK), .RST(RST), .RXD(RXD), .RXDV(RXDV), .RXER(RXER),
    .FIFO_WDAT(b_wdat), .FIFO_WEN(b_wen), .FIFO_WEOD(b_weod), .FIFO_WERR(b_werr),
    .FIFO_AFULL(FIFO_AFULL), .FIFO_WCNT(b_wcnt),
    .FRM_CNT(b_frm), .ERR_CNT(b_err), .DROP_CNT(b_drop));

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         due;
    logic [7:0] d;
    logic       eod;
    logic       err;
    int         cnt;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  exp_frm[2];
  int  exp_err[2];
  int  exp_drop[2];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  edge_n = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference CRC-32 (reflected, final inversion), i.e. the FCS value as transmitted
  function automatic logic [31:0] crc_ref(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input bq_t b);
    int n;
    logic [31:0] f;
    n = b.size();
    if (n < 4) return 1'b0;
    f = crc_ref(b, n - 4);
    return {b[n-1], b[n-2], b[n-3], b[n-4]} == f;
  endfunction

  function automatic bq_t make_body(input int n, input bit good);
    bq_t b;
    logic [31:0] f;
    if (n < 4) begin
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      return b;
    end
    for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
    f = crc_ref(b, n - 4);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    if (!good) begin
      int idx;
      idx = $urandom_range(0, n - 1);
      b[idx] = b[idx] ^ 8'($urandom_range(1, 255));
    end
    return b;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er,
                       input logic rst, input logic af);
    @(negedge RCLK);
    RXDV = dv; RXD = d; RXER = er; RST = rst; FIFO_AFULL = af;
    @(posedge RCLK);
    edge_n++;
  endtask

  task automatic chk_counters();
    chk("a_frm_cnt", int'(a_frm), exp_frm[0]);
    chk("a_err_cnt", int'(a_err), exp_err[0]);
    chk("a_drop_cnt", int'(a_drop), exp_drop[0]);
    chk("b_frm_cnt", int'(b_frm), exp_frm[1]);
    chk("b_err_cnt", int'(b_err), exp_err[1]);
    chk("b_drop_cnt", int'(b_drop), exp_drop[1]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outs"}, int'({a_wdat, a_wen, a_weod, a_werr, a_wcnt}), 0);
    chk({tag, "_b_outs"}, int'({b_wdat, b_wen, b_weod, b_werr, b_wcnt}), 0);
    chk({tag, "_a_cnts"}, int'(a_frm) + int'(a_err) + int'(a_drop), 0);
    chk({tag, "_b_cnts"}, int'(b_frm) + int'(b_err) + int'(b_drop), 0);
  endtask

  // Frame-level model: the outcome of a whole frame follows from its length, preamble,
  // RXER, FCS and AFULL; write k of the body appears one edge after body byte k+H is sampled.
  task automatic run_frame(input bq_t body, input int npre, input int bad_pre, input int er_idx,
                           input bit afull, input int gap, input int rst_idx,
                           output int nwa, output int nwb);
    int n, base, bs;
    n    = body.size();
    base = edge_n;
    bs   = npre + 1;
    nwa  = 0;
    nwb  = 0;
    for (int id = 0; id < 2; id++) begin
      int h, last;
      bit chk_fcs, err;
      wr_t w[$];
      wr_t e;
      h       = (id == 0) ? 5 : 1;
      chk_fcs = (id == 0);
      if (afull || bad_pre > 0) begin
        exp_drop[id]++;
      end else if (n > MAXL || n >= h) begin
        if (n > MAXL) begin
          last = MAXL - h + 1;
          err  = 1'b1;
        end else begin
          last = n - h + 1;
          err  = (er_idx >= 1 && er_idx <= n) || n < MINL || (chk_fcs && !fcs_ok(body));
        end
        for (int k = 1; k <= last; k++) begin
          e.due = base + bs + k + h + 1;
          e.d   = body[k-1];
          e.eod = (k == last);
          e.err = (k == last) && err;
          e.cnt = k % 2048;
          w.push_back(e);
        end
        if (err) exp_err[id]++;
        else     exp_frm[id]++;
      end else begin
        exp_drop[id]++;
      end
      if (rst_idx > 0) begin
        wr_t keep[$];
        foreach (w[i]) if (w[i].due < base + bs + rst_idx) keep.push_back(w[i]);
        w = keep;
        // After reset the rest of the frame is seen without its SFD and is dropped
        exp_frm[id]  = 0;
        exp_err[id]  = 0;
        exp_drop[id] = 1;
      end
      foreach (w[i]) begin
        if (id == 0) qa.push_back(w[i]);
        else         qb.push_back(w[i]);
      end
      if (id == 0) nwa = w.size();
      else         nwb = w.size();
    end

    for (int p = 0; p < npre; p++) drive(1'b1, (p == bad_pre && p > 0) ? 8'h5D : 8'h55, 1'b0, 1'b0, afull);
    drive(1'b1, 8'hD5, 1'b0, 1'b0, afull);
    for (int j = 1; j <= n; j++) begin
      drive(1'b1, body[j-1], (j == er_idx), (j == rst_idx), afull);
      if (j == rst_idx) begin
        #1;
        chk_all_zero("rst_mid");
      end
    end
    for (int g = 0; g < gap; g++) drive(1'b0, 8'h00, 1'b0, 1'b0, afull);
    FIFO_AFULL = 1'b0;
    if (gap >= 2) begin
      #1;
      chk_counters();
    end
  endtask

  task automatic cmp_wr(input int id, input logic wen, input logic [7:0] wdat, input logic weod,
                        input logic werr, input logic [10:0] wcnt);
    wr_t e;
    bit  has;
    has = 1'b0;
    if (id == 0 && qa.size() > 0 && qa[0].due <= edge_n) begin e = qa.pop_front(); has = 1'b1; end
    if (id == 1 && qb.size() > 0 && qb[0].due <= edge_n) begin e = qb.pop_front(); has = 1'b1; end
    n_cmp++;
    if (has) begin
      if (e.due != edge_n || !wen || wdat != e.d || weod != e.eod ||
          (e.eod && werr != e.err) || int'(wcnt) != e.cnt) begin
        n_fail++;
        $display("FAIL write dut%0d edge %0d: got wen=%0b dat=%02h eod=%0b err=%0b cnt=%0d expected due=%0d dat=%02h eod=%0b err=%0b cnt=%0d",
                 id, edge_n, wen, wdat, weod, werr, wcnt, e.due, e.d, e.eod, e.err, e.cnt);
      end
    end else if (wen) begin
      n_fail++;
      $display("FAIL idle dut%0d edge %0d: got wen=1 dat=%02h expected wen=0", id, edge_n, wdat);
    end
  endtask

  always @(negedge RCLK) begin
    if (chk_en) begin
      cmp_wr(0, a_wen, a_wdat, a_weod, a_werr, a_wcnt);
      cmp_wr(1, b_wen, b_wdat, b_weod, b_werr, b_wcnt);
    end
  end

  initial begin
    bq_t b1, b2, b3, bg, br, bs9;
    int  nwa, nwb;

    bs9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_ref_pin", int'(crc_ref(bs9, 9)), int'(32'hCBF43926));
    for (int i = 0; i < 2; i++) begin exp_frm[i] = 0; exp_err[i] = 0; exp_drop[i] = 0; end

    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    chk_all_zero("reset");
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    b1 = make_body(64, 1'b1);
    chk("t1_fcs_pin", int'(fcs_ok(b1)), 1);
    run_frame(b1, 7, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t1_writes_a", nwa, 60);
    chk("t1_writes_b", nwb, 64);
    chk("t1_frm_a", int'(a_frm), 1);

    b2 = b1;
    b2[10] = b2[10] ^ 8'h40;
    run_frame(b2, 7, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t2_err_a", int'(a_err), 1);
    chk("t2_frm_a", int'(a_frm), 1);

    b3 = make_body(64, 1'b1);
    run_frame(b3, 7, 0, 30, 1'b0, 3, 0, nwa, nwb);
    chk("t3_rxer_err_b", int'(b_err), 1);
    run_frame(b3, 7, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t3_writes_b", nwb, 64);
    chk("t3_frm_b", int'(b_frm), 3);

    bg = make_body(1600, 1'b1);
    run_frame(bg, 7, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t4_writes_b", nwb, 1518);
    chk("t4_writes_a", nwa, 1514);
    chk("t4_err_b", int'(b_err), 2);

    run_frame(make_body(1518, 1'b1), 3, 0, 0, 1'b0, 2, 0, nwa, nwb);
    run_frame(make_body(1519, 1'b1), 3, 0, 0, 1'b0, 2, 0, nwa, nwb);
    run_frame(make_body(4, 1'b1), 3, 0, 0, 1'b0, 2, 0, nwa, nwb);
    run_frame(make_body(5, 1'b1), 3, 0, 0, 1'b0, 2, 0, nwa, nwb);
    run_frame(make_body(63, 1'b1), 3, 0, 0, 1'b0, 2, 0, nwa, nwb);

    for (int i = 0; i < 2; i++) begin exp_frm[i] = 0; exp_err[i] = 0; exp_drop[i] = 0; end
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame(make_body(64, 1'b1), 7, 0, 0, 1'b1, 3, 0, nwa, nwb);
    chk("t5_afull_drop_a", int'(a_drop), 1);
    chk("t5_afull_writes", nwa + nwb, 0);
    run_frame(make_body(64, 1'b1), 7, 3, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t5_badpre_drop_a", int'(a_drop), 2);
    run_frame(make_body(70, 1'b1), 7, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t5_good_frm_a", int'(a_frm), 1);

    for (int i = 0; i < 100; i++) br.push_back(8'h80 | 8'((i * 7) & 8'h3F));
    run_frame(br, 7, 0, 0, 1'b0, 3, 30, nwa, nwb);
    chk("t6_rst_drop_a", int'(a_drop), 1);
    chk("t6_rst_frm_a", int'(a_frm), 0);
    run_frame(make_body(64, 1'b1), 7, 0, 0, 1'b0, 1, 0, nwa, nwb);
    run_frame(make_body(66, 1'b1), 2, 0, 0, 1'b0, 3, 0, nwa, nwb);
    chk("t6_b2b_frm_a", int'(a_frm), 2);
    chk("t6_b2b_frm_b", int'(b_frm), 2);

    for (int f = 0; f < 40; f++) begin
      int  n, npre, bad, er, gap, sel;
      bit  good, af;
      sel  = $urandom_range(0, 19);
      n    = (sel < 5) ? $urandom_range(1, 6) : (sel < 8) ? $urandom_range(7, 63) : $urandom_range(64, 200);
      good = ($urandom_range(0, 4) != 0);
      npre = $urandom_range(2, 7);
      bad  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, npre - 1) : 0;
      er   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n) : 0;
      af   = ($urandom_range(0, 9) == 0);
      gap  = $urandom_range(1, 3);
      run_frame(make_body(n, good), npre, bad, er, af, gap, 0, nwa, nwb);
    end

    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    chk_counters();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
